// File: rtl/alu_div_pkg.sv
// -----------------------------------------------------------------------------
// alu_div_pkg
// Shared types and constants for the sequential ALU divider.
//   WIDTH_DEFAULT : default operand width of the divider datapath
//   CNT_W         : iteration counter width for the default operand width
//   div_state_e   : divider controller states
// -----------------------------------------------------------------------------
package alu_div_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/alu_div_step.sv
// -----------------------------------------------------------------------------
// alu_div_step
// One combinational non-restoring division iteration.
//   a      : (WIDTH+1)-bit signed partial remainder
//   q      : WIDTH-bit quotient/dividend shift register
//   m      : WIDTH-bit divisor magnitude
//   a_next : partial remainder after shift and add/subtract
//   q_next : shift register with the new quotient bit in bit 0
// -----------------------------------------------------------------------------
module alu_div_step
  import alu_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] a_shift_s;
  logic [WIDTH:0] m_ext_s;
  logic [WIDTH:0] a_sum_s;

  // Shift {A,Q} left, then subtract M from a non-negative A or add it to a
  // negative one; the new quotient bit is set when the result is non-negative.
  always_comb begin
    a_shift_s = {a[WIDTH-1:0], q[WIDTH-1]};
    m_ext_s   = {1'b0, m};
    if (a[WIDTH] == 1'b0) begin
      a_sum_s = a_shift_s - m_ext_s;
    end else begin
      a_sum_s = a_shift_s + m_ext_s;
    end
    a_next = a_sum_s;
    q_next = {q[WIDTH-2:0], ~a_sum_s[WIDTH]};
  end

endmodule

// File: rtl/alu_divider.sv
// -----------------------------------------------------------------------------
// alu_divider
// Sequential radix-2 non-restoring divider, one quotient bit per cycle.
// Result layout matches the multiplier HI/LO: {remainder, quotient}.
//   clock    : rising-edge clock
//   reset    : synchronous active-high reset, overrides everything
//   start    : request, only looked at in IDLE
//   dividend : numerator, sampled in LOAD
//   divisor  : denominator, sampled in LOAD
//   busy     : high from the accepting edge through the done cycle
//   done     : one-cycle pulse, result valid
//   div_zero : divisor was zero (only with ALU_DIV_ZERO_TRAP_EN)
//   result   : {remainder, quotient}, held until the next operation's FIX
// Build option:
//   ALU_DIV_ZERO_TRAP_EN : a zero divisor bypasses the iterations and
//                          flags div_zero; otherwise it runs full latency
//                          and div_zero stays 0.
// -----------------------------------------------------------------------------
module alu_divider
  import alu_div_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int                 CNT_BITS = $clog2(WIDTH);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WIDTH - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  div_state_e          state_r;
  logic [WIDTH:0]      a_r;
  logic [WIDTH-1:0]    q_r;
  logic [WIDTH-1:0]    m_r;
  logic [WIDTH-1:0]    dividend_r;
  logic                sign_q_r;
  logic                sign_rem_r;
  logic                zero_r;
  logic [CNT_BITS-1:0] count_r;

  logic [WIDTH:0]      a_next_s;
  logic [WIDTH-1:0]    q_next_s;
  logic [WIDTH-1:0]    rem_mag_s;
  logic [WIDTH-1:0]    fix_q_s;
  logic [WIDTH-1:0]    fix_rem_s;

  // Operand magnitude; the plain WIDTH-bit negate leaves the most negative
  // value unchanged, which the unsigned datapath then handles correctly.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] mag;
    if (SIGNED && x[WIDTH-1]) begin
      mag = -x;
    end else begin
      mag = x;
    end
    return mag;
  endfunction

  alu_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a      (a_r),
    .q      (q_r),
    .m      (m_r),
    .a_next (a_next_s),
    .q_next (q_next_s)
  );

  // Final correction: restore a negative remainder, apply result signs, and
  // force the divide-by-zero convention q = all ones, r = raw dividend.
  always_comb begin
    if (a_r[WIDTH]) begin
      rem_mag_s = a_r[WIDTH-1:0] + m_r;
    end else begin
      rem_mag_s = a_r[WIDTH-1:0];
    end
    if (zero_r) begin
      fix_q_s   = {WIDTH{1'b1}};
      fix_rem_s = dividend_r;
    end else begin
      if (sign_q_r) begin
        fix_q_s = -q_r;
      end else begin
        fix_q_s = q_r;
      end
      if (sign_rem_r) begin
        fix_rem_s = -rem_mag_s;
      end else begin
        fix_rem_s = rem_mag_s;
      end
    end
  end

  // Controller, datapath registers and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      a_r        <= {(WIDTH+1){1'b0}};
      q_r        <= {WIDTH{1'b0}};
      m_r        <= {WIDTH{1'b0}};
      dividend_r <= {WIDTH{1'b0}};
      sign_q_r   <= 1'b0;
      sign_rem_r <= 1'b0;
      zero_r     <= 1'b0;
      count_r    <= {CNT_BITS{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      result     <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start) begin
            state_r <= LOAD;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end

        LOAD: begin
          a_r        <= {(WIDTH+1){1'b0}};
          q_r        <= magnitude(dividend);
          m_r        <= magnitude(divisor);
          dividend_r <= dividend;
          sign_q_r   <= SIGNED & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          sign_rem_r <= SIGNED & dividend[WIDTH-1];
          zero_r     <= (divisor == {WIDTH{1'b0}});
          count_r    <= {CNT_BITS{1'b0}};
`ifdef ALU_DIV_ZERO_TRAP_EN
          if (divisor == {WIDTH{1'b0}}) begin
            result   <= {dividend, {WIDTH{1'b1}}};
            done     <= 1'b1;
            div_zero <= 1'b1;
            state_r  <= DONE;
          end else begin
            state_r  <= CALC;
          end
`else
          state_r <= CALC;
`endif
        end

        CALC: begin
          a_r     <= a_next_s;
          q_r     <= q_next_s;
          count_r <= count_r + CNT_ONE;
          if (count_r == CNT_LAST) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end

        FIX: begin
          result  <= {fix_rem_s, fix_q_s};
          done    <= 1'b1;
          state_r <= DONE;
        end

        DONE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end

        default: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// -----------------------------------------------------------------------------
// tb_alu_divider
// Directed self-checking bench for alu_divider: a signed instance and an
// unsigned instance share clock, reset and stimulus.
// -----------------------------------------------------------------------------
module tb_alu_divider;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [63:0] result;
  logic        busy_u;
  logic        done_u;
  logic        div_zero_u;
  logic [63:0] result_u;

  int tests_run;
  int tests_failed;

  alu_divider #(
    .WIDTH  (32),
    .SIGNED (1'b1)
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .result   (result)
  );

  alu_divider #(
    .WIDTH  (32),
    .SIGNED (1'b0)
  ) u_dut_u (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy_u),
    .done     (done_u),
    .div_zero (div_zero_u),
    .result   (result_u)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start one operation, hold operands through LOAD, then wait for done.
  // exp_lat < 0 skips the latency and busy-length checks.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [63:0] exp_res, input logic exp_dz);
    int n;
    int busy_cnt;
    @(negedge clock);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    @(negedge clock);
    start    = 1'b0;
    n        = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    if (busy === 1'b1) busy_cnt++;
    if (exp_lat >= 0) begin
      check({tag, "_lat"}, 64'(n), 64'(exp_lat));
      check({tag, "_busy_len"}, 64'(busy_cnt), 64'(exp_lat + 1));
    end
    check({tag, "_res"}, result, exp_res);
    check({tag, "_dz"}, {63'd0, div_zero}, {63'd0, exp_dz});
    @(posedge clock);
    @(negedge clock);
    check({tag, "_done_drop"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int n;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    start        = 1'b0;
    dividend     = 32'd0;
    divisor      = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
    check("rst_result", result, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_flags", {61'd0, busy, done, div_zero}, 64'd0);

    run_op("p7_2",   32'd7,          32'd2,          34, 64'h00000001_00000003, 1'b0);
    run_op("m7_2",   32'hFFFFFFF9,   32'd2,          34, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_op("p7_m2",  32'd7,          32'hFFFFFFFE,   34, 64'h00000001_FFFFFFFD, 1'b0);
    run_op("ovf",    32'h80000000,   32'hFFFFFFFF,   34, 64'h00000000_80000000, 1'b0);
    run_op("m1_16",  32'hFFFFFFFF,   32'h00000010,   34, 64'hFFFFFFFF_00000000, 1'b0);
    check("u_ffff_16", result_u, 64'h0000000F_0FFFFFFF);
    run_op("p1000_7", 32'd1000,      32'd7,          34, 64'h00000006_0000008E, 1'b0);

    // Result must stay put while inputs wander in IDLE.
    dividend = 32'h12345678;
    divisor  = 32'h0000BEEF;
    repeat (5) @(negedge clock);
    check("hold_res", result, 64'h00000006_0000008E);

`ifdef ALU_DIV_ZERO_TRAP_EN
    run_op("div0", 32'd5, 32'd0, -1, 64'h00000005_FFFFFFFF, 1'b1);
`else
    run_op("div0", 32'd5, 32'd0, 34, 64'h00000005_FFFFFFFF, 1'b0);
    check("u_div0", result_u, 64'h00000005_FFFFFFFF);
`endif

    // A second start while busy is ignored.
    @(negedge clock);
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    n     = 0;
    while (done !== 1'b1 && n < 100) begin
      if (n == 10) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    check("ign_lat", 64'(n), 64'd34);
    check("ign_res", result, 64'h00000002_0000000E);
    repeat (3) @(negedge clock);
    check("ign_no_restart", {62'd0, busy, done}, 64'd0);

    // Reset in flight discards the operation.
    @(negedge clock);
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_flags", {62'd0, busy, done}, 64'd0);
    check("mid_rst_res", result, 64'd0);
    run_op("p9_3", 32'd9, 32'd3, 34, 64'h00000000_00000003, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
